// File: rtl/rx_bit_decoder_pkg.sv
// Shared definitions for the receive bit decoder: record codes, line codes,
// decoder states and the record packing helper.
package rx_bit_decoder_pkg;

    localparam int REC_W = 16;

    localparam logic [7:0] DATA_START           = 8'h01;
    localparam logic [7:0] DATA_STOP            = 8'h02;
    localparam logic [7:0] DATA_STREAM          = 8'h03;
    localparam logic [7:0] DATA_BIT_STUFF_ERROR = 8'h04;

    localparam logic [1:0] SE0 = 2'b00;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DATA        = 2'd1,
        WAIT_RESUME = 2'd2,
        RESUME_END  = 2'd3
    } rx_state_t;

    // A record is the code byte in the upper half and the data byte in the lower half.
    function automatic logic [REC_W-1:0] make_rec(input logic [7:0] code, input logic [7:0] data);
        return {code, data};
    endfunction

endpackage

// File: rtl/rx_bit_decoder_rec_fifo.sv
// Synchronous record FIFO with occupancy output. Push into a full FIFO and
// pop from an empty one are prevented by the caller.
module rx_rec_fifo
    import rx_bit_decoder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [REC_W-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [REC_W-1:0]       head_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [REC_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;

    // Storage, pointers and occupancy; pointers wrap naturally for a power-of-2 depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {REC_W{1'b0}};
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {(AW+1){1'b0}};
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/rx_bit_decoder.sv
// Receive bit decoder: NRZI decode and de-stuffing of line samples, LSB-first
// byte assembly, record generation into a FIFO and resume detection.
module rx_bit_decoder
    import rx_bit_decoder_pkg::*;
#(
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_SAME_LEVELS = 7,
    parameter int RESUME_WAIT     = 10,
    parameter int EOP_SE0_BITS    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  JBit,
    input  logic [1:0]                  KBit,
    input  logic [1:0]                  RxBitsIn,
    input  logic                        processRxBitsWEn,
    output logic                        processRxBitRdy,
    output logic [7:0]                  RxDataOut,
    output logic [7:0]                  RxCtrlOut,
    output logic                        processRxByteWEn,
    input  logic                        processRxByteRdy,
    output logic                        resumeDetected,
    output logic [$clog2(FIFO_DEPTH):0] fifoLevel
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(MAX_SAME_LEVELS + 1);
    localparam int EW = $clog2(EOP_SE0_BITS + 1);
    localparam int RW = $clog2(RESUME_WAIT + 1);

    localparam logic [SW-1:0] SAME_MAX    = SW'(MAX_SAME_LEVELS);
    localparam logic [EW-1:0] SE0_LAST    = EW'(EOP_SE0_BITS - 1);
    localparam logic [RW-1:0] RES_LAST    = RW'(RESUME_WAIT - 1);
    localparam logic [LW-1:0] LVL_RDY_MAX = LW'(FIFO_DEPTH - 2);

    rx_state_t        state_q, state_d;
    logic [1:0]       old_bits_q, old_bits_d;
    logic [SW-1:0]    same_cnt_q, same_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       byte_q, byte_d;
    logic [EW-1:0]    se0_cnt_q, se0_cnt_d;
    logic [RW-1:0]    res_cnt_q, res_cnt_d;
    logic             resume_q, resume_d;
    logic             rdy_q, rdy_d;
    logic             wen_q;
    logic [7:0]       data_q;
    logic [7:0]       ctrl_q;

    logic             accept_s;
    logic             push_s;
    logic [REC_W-1:0] push_rec_s;
    logic             pop_s;
    logic             shift_s;
    logic             shift_bit_s;
    logic [REC_W-1:0] head_s;
    logic [LW-1:0]    fifo_level_s;
    logic [LW-1:0]    lvl_next_s;

    assign accept_s = processRxBitsWEn & rdy_q;

    // Per-sample decode: state transitions, NRZI/de-stuff and record selection.
    always_comb begin
        state_d     = state_q;
        old_bits_d  = old_bits_q;
        same_cnt_d  = same_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        byte_d      = byte_q;
        se0_cnt_d   = se0_cnt_q;
        res_cnt_d   = res_cnt_q;
        resume_d    = resume_q;
        push_s      = 1'b0;
        push_rec_s  = {REC_W{1'b0}};
        shift_s     = 1'b0;
        shift_bit_s = 1'b0;
        if (accept_s) begin
            case (state_q)
                IDLE: begin
                    if (RxBitsIn == KBit) begin
                        push_s     = 1'b1;
                        push_rec_s = make_rec(DATA_START, 8'h00);
                        old_bits_d = KBit;
                        same_cnt_d = SW'(1);
                        bit_cnt_d  = 3'd1;
                        byte_d     = 8'h00;
                        se0_cnt_d  = {EW{1'b0}};
                        state_d    = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end
                DATA: begin
                    if (RxBitsIn == SE0) begin
                        if (se0_cnt_q == SE0_LAST) begin
                            push_s     = 1'b1;
                            push_rec_s = make_rec(DATA_STOP, 8'h00);
                            se0_cnt_d  = {EW{1'b0}};
                            state_d    = IDLE;
                        end else begin
                            se0_cnt_d = se0_cnt_q + EW'(1);
                        end
                    end else begin
                        se0_cnt_d  = {EW{1'b0}};
                        old_bits_d = RxBitsIn;
                        if (RxBitsIn == old_bits_q) begin
                            if (same_cnt_q == SAME_MAX) begin
                                push_s     = 1'b1;
                                push_rec_s = make_rec(DATA_BIT_STUFF_ERROR, 8'h00);
                                res_cnt_d  = {RW{1'b0}};
                                state_d    = (RxBitsIn == JBit) ? IDLE : WAIT_RESUME;
                            end else begin
                                shift_s     = 1'b1;
                                shift_bit_s = 1'b1;
                                same_cnt_d  = same_cnt_q + SW'(1);
                            end
                        end else begin
                            // A transition after a maximal run is the stuffed bit and carries no data.
                            same_cnt_d  = SW'(1);
                            shift_s     = (same_cnt_q != SAME_MAX);
                            shift_bit_s = 1'b0;
                        end
                        if (shift_s) begin
                            byte_d = {shift_bit_s, byte_q[7:1]};
                            if (bit_cnt_q == 3'd7) begin
                                push_s     = 1'b1;
                                push_rec_s = make_rec(DATA_STREAM, {shift_bit_s, byte_q[7:1]});
                                bit_cnt_d  = 3'd0;
                            end else begin
                                bit_cnt_d = bit_cnt_q + 3'd1;
                            end
                        end else begin
                            byte_d = byte_q;
                        end
                    end
                end
                WAIT_RESUME: begin
                    if (RxBitsIn != KBit) begin
                        state_d = IDLE;
                    end else if (res_cnt_q == RES_LAST) begin
                        resume_d = 1'b1;
                        state_d  = RESUME_END;
                    end else begin
                        res_cnt_d = res_cnt_q + RW'(1);
                    end
                end
                RESUME_END: begin
                    if (RxBitsIn != KBit) begin
                        resume_d = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        state_d = RESUME_END;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output side: pop spacing, occupancy after this cycle's push/pop, and input readiness.
    always_comb begin
        pop_s      = (fifo_level_s != {LW{1'b0}}) & processRxByteRdy & ~wen_q;
        lvl_next_s = fifo_level_s + LW'(push_s) - LW'(pop_s);
        rdy_d      = (lvl_next_s <= LVL_RDY_MAX);
    end

    rx_rec_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_s),
        .push_data_i (push_rec_s),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .level_o     (fifo_level_s)
    );

    // Decoder state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            old_bits_q <= 2'b00;
            same_cnt_q <= {SW{1'b0}};
            bit_cnt_q  <= 3'd0;
            byte_q     <= 8'h00;
            se0_cnt_q  <= {EW{1'b0}};
            res_cnt_q  <= {RW{1'b0}};
            resume_q   <= 1'b0;
            rdy_q      <= 1'b1;
            wen_q      <= 1'b0;
            data_q     <= 8'h00;
            ctrl_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            old_bits_q <= old_bits_d;
            same_cnt_q <= same_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_q     <= byte_d;
            se0_cnt_q  <= se0_cnt_d;
            res_cnt_q  <= res_cnt_d;
            resume_q   <= resume_d;
            rdy_q      <= rdy_d;
            wen_q      <= pop_s;
            if (pop_s) begin
                data_q <= head_s[7:0];
                ctrl_q <= head_s[15:8];
            end
        end
    end

    assign processRxBitRdy  = rdy_q;
    assign processRxByteWEn = wen_q;
    assign RxDataOut        = data_q;
    assign RxCtrlOut        = ctrl_q;
    assign resumeDetected   = resume_q;
    assign fifoLevel        = fifo_level_s;

endmodule
